// File: rtl/ofmap_deskew_collector.sv
// ofmap_deskew_collector
// Collects skewed per-column MAC results into per-lane FIFOs and releases
// them as column-aligned rows through a valid/ready output register.
// Optional feature: define OFMAP_RELU_EN to clamp negative lane values to 0
// on their way into the output register.
module ofmap_deskew_collector #(
    parameter int MAC_COL        = 16,
    parameter int OFMAP_BITWIDTH = 32,
    parameter int FIFO_DEPTH     = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_in,
    input  logic [15:0]                       num_in,
    input  logic [MAC_COL-1:0]                ofmap_valid_in,
    input  logic [MAC_COL*OFMAP_BITWIDTH-1:0] ofmap_data_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [MAC_COL*OFMAP_BITWIDTH-1:0] out_data,
    output logic                              done_out,
    output logic                              overflow_err
);
    localparam int W  = OFMAP_BITWIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t               state_q, state_d;
    logic [15:0]          num_q, num_d;
    logic [15:0]          row_cnt_q, row_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [MAC_COL*W-1:0] out_data_q, out_data_d;
    logic                 ovf_q, ovf_d;

    logic                 start_acc;
    logic                 fifo_clr;
    logic                 hs;
    logic                 last_hs;
    logic                 pop;
    logic [MAC_COL-1:0]   lane_empty;
    logic [MAC_COL-1:0]   lane_full;
    logic [MAC_COL-1:0]   lane_drop;
    logic [MAC_COL*W-1:0] head_flat;

    assign start_acc = (state_q == IDLE) && start_in;
    assign fifo_clr  = start_acc;
    assign hs        = out_valid_q && out_ready;
    assign last_hs   = (state_q == COLLECT) && hs && (row_cnt_q == num_q - 16'd1);
    // The final row's handshake never refills the output register, so the
    // frame ends with the output stage empty.
    assign pop       = (state_q == COLLECT) && !(|lane_empty)
                       && (!out_valid_q || out_ready) && !last_hs;

    generate
        for (genvar gi = 0; gi < MAC_COL; gi++) begin : g_lane
            logic [W-1:0]        mem_q [FIFO_DEPTH];
            logic [AW:0]         wr_ptr_q;
            logic [AW:0]         rd_ptr_q;
            logic                wr_req;
            logic                wr_ok;
            logic signed [W-1:0] head;

            assign wr_req         = ofmap_valid_in[gi] && (state_q == COLLECT);
            assign lane_empty[gi] = (wr_ptr_q == rd_ptr_q);
            assign lane_full[gi]  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
                                    && (wr_ptr_q[AW] != rd_ptr_q[AW]);
            // A full lane still accepts a write when it pops in the same cycle.
            assign wr_ok          = wr_req && (!lane_full[gi] || pop);
            assign lane_drop[gi]  = wr_req && lane_full[gi] && !pop;
            assign head           = mem_q[rd_ptr_q[AW-1:0]];

`ifdef OFMAP_RELU_EN
            assign head_flat[gi*W +: W] = head[W-1] ? '0 : head;
`else
            assign head_flat[gi*W +: W] = head;
`endif

            // Lane FIFO pointers; cleared by reset or by a new frame.
            always_ff @(posedge clk) begin
                if (rst || fifo_clr) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    if (wr_ok) begin
                        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
                    end
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
                    end
                end
            end

            // Lane storage array; contents are don't-care until written.
            always_ff @(posedge clk) begin
                if (wr_ok) begin
                    mem_q[wr_ptr_q[AW-1:0]] <= ofmap_data_in[gi*W +: W];
                end
            end
        end
    endgenerate

    // Next-state logic for the frame FSM, output register and error flag.
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        row_cnt_d   = row_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    num_d     = num_in;
                    row_cnt_d = '0;
                    state_d   = (num_in == 16'd0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (hs) begin
                    row_cnt_d = row_cnt_q + 16'd1;
                    if (last_hs) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = head_flat;
        end else if (hs) begin
            out_valid_d = 1'b0;
        end

        // Clear on frame start first so a same-cycle error still registers.
        if (start_acc) begin
            ovf_d = 1'b0;
        end
        if ((|lane_drop) || ((state_q != COLLECT) && (|ofmap_valid_in))) begin
            ovf_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            num_q       <= '0;
            row_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            row_cnt_q   <= row_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign done_out     = (state_q == DONE);
    assign overflow_err = ovf_q;

endmodule
